ofm_pre_se_reader: RTL

Read-side sequencer for the pre-SE output-feature-map buffer. On `start` it walks a contiguous run of words in the buffer, drives the buffer's byte-granular read address (word index × 4), and absorbs the buffer's registered read latency. It re-emits the words as a valid/ready stream toward the squeeze-excitation stage, holding a small credit-managed FIFO so that downstream backpressure never drops a word.

---
 rtl/ofm_pre_se_reader.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ofm_pre_se_reader.sv
// Read sequencer for the pre-SE OFM buffer: issues word reads, absorbs the 2-cycle read latency,
// and replays the words as a credit-protected valid/ready stream. Optional: OFM_RD_STALL_CNT_EN.
module ofm_pre_se_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 20,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  num_words,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] bram_rd_addr,
    input  logic [DATA_WIDTH-1:0] bram_data_in,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
`ifdef OFM_RD_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_issued;
    logic [LEN_WIDTH-1:0]  r_accepted;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_v1;
    logic                  r_v2;

    logic [DATA_WIDTH-1:0] r_fifo [4];
    logic [1:0]            r_wr_ptr;
    logic [1:0]            r_rd_ptr;
    logic [2:0]            r_count;

    logic                  w_start_ok;
    logic                  w_credit;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_last_acc;
    logic [LEN_WIDTH-1:0]  w_last_idx;
    logic [ADDR_WIDTH-1:0] w_issue_idx;
    logic [ADDR_WIDTH-1:0] w_issue_addr;

    // Credit counts everything already committed to the FIFO; a same-cycle pop is deliberately ignored.
    assign w_credit     = ({1'b0, r_count} + 4'(r_v1) + 4'(r_v2)) < 4'd4;
    assign w_start_ok   = (r_state == S_IDLE) && start;
    assign w_issue      = (w_start_ok && (num_words != '0)) || ((r_state == S_ISSUE) && w_credit);
    assign w_push       = r_v2;
    assign w_pop        = m_valid && m_ready;
    assign w_last_idx   = r_len - LEN_WIDTH'(1);
    assign w_last_acc   = w_pop && (r_accepted == w_last_idx);
    assign w_issue_idx  = w_start_ok ? base_addr : r_base + ADDR_WIDTH'(r_issued);
    assign w_issue_addr = w_issue_idx << 2;

    assign busy         = r_busy;
    assign done         = r_done;
    assign bram_rd_addr = r_addr;
    assign m_valid      = (r_count != 3'd0);
    assign m_data       = m_valid ? r_fifo[r_rd_ptr] : '0;
    assign m_last       = m_valid && (r_accepted == w_last_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_accepted <= '0;
            r_addr     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere here so every branch sees the pre-edge register values.
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A zero-length request still shows busy for the single cycle that carries done.
                    r_busy <= start;
                    if (start) begin
                        r_base     <= base_addr;
                        r_len      <= num_words;
                        r_accepted <= '0;
                        r_issued   <= (num_words != '0) ? LEN_WIDTH'(1) : '0;
                        if (num_words == '0)
                            r_done <= 1'b1;
                        else if (num_words == LEN_WIDTH'(1))
                            r_state <= S_DRAIN;
                        else
                            r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_credit) begin
                        r_issued <= r_issued + LEN_WIDTH'(1);
                        if (r_issued == w_last_idx)
                            r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_last_acc) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_pop)
                r_accepted <= r_accepted + LEN_WIDTH'(1);
            if (w_issue)
                r_addr <= w_issue_addr;
            r_v1 <= w_issue;
            r_v2 <= r_v1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 2'd1;
            r_count <= r_count + 3'(w_push) - 3'(w_pop);
        end
    end

    // NOTE: FIFO storage has no reset; m_data is masked by m_valid so stale contents never escape.
    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wr_ptr] <= bram_data_in;
    end

`ifdef OFM_RD_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (w_start_ok)
            r_stall_cnt <= '0;
        else if (m_valid && !m_ready && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
